// File: rtl/cache_ctrl.sv
// Direct-mapped cache controller in front of one CacheWay (tag + line storage only).
// Owns the per-set valid/dirty bits and runs misses as optional writeback, then line refill.
module cache_ctrl #(
  parameter int ADDR_WIDTH       = 5,
  parameter int TAG_BITS         = 23,
  parameter int WHOLE_DATA_WIDTH = 128,
  parameter int BANK_DATA_WIDTH  = 32,
  parameter int DATA_WORD_NUM    = 4,
  parameter int DATA_BYTE_NUM    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_req_valid,
  input  logic                        cpu_req_we,
  input  logic [31:0]                 cpu_req_addr,
  input  logic [BANK_DATA_WIDTH-1:0]  cpu_req_wdata,
  input  logic [DATA_BYTE_NUM-1:0]    cpu_req_byte_en,
  output logic                        cpu_req_ready,
  output logic                        cpu_resp_valid,
  output logic [BANK_DATA_WIDTH-1:0]  cpu_resp_rdata,
  output logic [ADDR_WIDTH-1:0]       way_addr,
  output logic                        way_wr_en,
  output logic [WHOLE_DATA_WIDTH-1:0] way_wr_data,
  output logic [TAG_BITS-1:0]         way_wr_tag,
  output logic [DATA_WORD_NUM-1:0]    way_wr_word_en,
  output logic [DATA_BYTE_NUM-1:0]    way_wr_byte_en,
  input  logic [TAG_BITS-1:0]         way_tag_data,
  input  logic [WHOLE_DATA_WIDTH-1:0] way_rd_data,
  output logic                        mem_req_valid,
  output logic                        mem_req_we,
  output logic [31:0]                 mem_req_addr,
  output logic [WHOLE_DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                        mem_req_ready,
  input  logic                        mem_resp_valid,
  input  logic [WHOLE_DATA_WIDTH-1:0] mem_resp_rdata
);
  localparam int SETS      = 1 << ADDR_WIDTH;
  localparam int WORD_BITS = $clog2(DATA_WORD_NUM);

  // Handshake: cpu_req and mem_req transfer on a clock edge where valid & ready are both 1;
  // the requester holds valid and payload stable until then, and ready depends on state only.
  // cpu_resp_valid and mem_resp_valid are single-cycle pulses with no back-pressure.
  typedef enum logic [2:0] {
    IDLE, LOOKUP, WRITEBACK, REFILL, REFILL_WAIT, SETTLE
  } state_t;

  state_t                      state, next_state;
  logic                        req_we;
  logic [TAG_BITS-1:0]         req_tag;
  logic [ADDR_WIDTH-1:0]       req_idx;
  logic [WORD_BITS-1:0]        req_word;
  logic [BANK_DATA_WIDTH-1:0]  req_wdata;
  logic [DATA_BYTE_NUM-1:0]    req_byte_en;
  logic [TAG_BITS-1:0]         victim_tag;
  logic [WHOLE_DATA_WIDTH-1:0] victim_line;
  logic [SETS-1:0]             valid_bits, dirty_bits;
  logic                        hit, victim_dirty, mark_dirty, fill_line;
  logic [BANK_DATA_WIDTH-1:0]  rd_word;
  logic                        addr_byte_unused;

  // Byte offset is irrelevant: loads return whole words, stores use byte enables.
  assign addr_byte_unused = ^cpu_req_addr[1:0];

  assign hit          = valid_bits[req_idx] && (way_tag_data == req_tag);
  assign victim_dirty = valid_bits[req_idx] && dirty_bits[req_idx];
  assign rd_word      = way_rd_data[{req_word, 5'b0} +: BANK_DATA_WIDTH];

  always_comb begin
    next_state     = state;
    cpu_req_ready  = (state == IDLE);
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = '0;
    way_addr       = (state == IDLE) ? cpu_req_addr[4 +: ADDR_WIDTH] : req_idx;
    way_wr_en      = 1'b0;
    way_wr_data    = '0;
    way_wr_tag     = '0;
    way_wr_word_en = '0;
    way_wr_byte_en = '0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;
    mark_dirty     = 1'b0;
    fill_line      = 1'b0;
    // Outputs are forced quiet while reset is held so an in-flight fill cannot reach CacheWay.
    if (!rst) begin
      unique case (state)
        IDLE: if (cpu_req_valid) next_state = LOOKUP;
        LOOKUP: begin
          if (hit) begin
            cpu_resp_valid = 1'b1;
            next_state     = IDLE;
            if (req_we) begin
              way_wr_en      = 1'b1;
              way_wr_word_en = DATA_WORD_NUM'(1) << req_word;
              way_wr_byte_en = req_byte_en;
              way_wr_data    = {DATA_WORD_NUM{req_wdata}};
              way_wr_tag     = req_tag;
              mark_dirty     = 1'b1;
            end else begin
              cpu_resp_rdata = rd_word;
            end
          end else if (victim_dirty) begin
            next_state = WRITEBACK;
          end else begin
            next_state = REFILL;
          end
        end
        WRITEBACK: begin
          mem_req_valid = 1'b1;
          mem_req_we    = 1'b1;
          mem_req_addr  = {victim_tag, req_idx, 4'b0};
          mem_req_wdata = victim_line;
          if (mem_req_ready) next_state = REFILL;
        end
        REFILL: begin
          mem_req_valid = 1'b1;
          mem_req_addr  = {req_tag, req_idx, 4'b0};
          if (mem_req_ready) next_state = REFILL_WAIT;
        end
        REFILL_WAIT: begin
          if (mem_resp_valid) begin
            way_wr_en      = 1'b1;
            way_wr_word_en = '1;
            way_wr_byte_en = '1;
            way_wr_data    = mem_resp_rdata;
            way_wr_tag     = req_tag;
            fill_line      = 1'b1;
            next_state     = SETTLE;
          end
        end
        // Gives CacheWay a cycle to present the new line before the replayed compare.
        SETTLE: next_state = LOOKUP;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valid_bits  <= '0;
      dirty_bits  <= '0;
      req_we      <= 1'b0;
      req_tag     <= '0;
      req_idx     <= '0;
      req_word    <= '0;
      req_wdata   <= '0;
      req_byte_en <= '0;
      victim_tag  <= '0;
      victim_line <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && cpu_req_valid) begin
        req_we      <= cpu_req_we;
        req_tag     <= cpu_req_addr[31 -: TAG_BITS];
        req_idx     <= cpu_req_addr[4 +: ADDR_WIDTH];
        req_word    <= cpu_req_addr[2 +: WORD_BITS];
        req_wdata   <= cpu_req_wdata;
        req_byte_en <= cpu_req_byte_en;
      end
      if (state == LOOKUP) begin
        victim_tag  <= way_tag_data;
        victim_line <= way_rd_data;
      end
      if (mark_dirty) dirty_bits[req_idx] <= 1'b1;
      if (fill_line) begin
        valid_bits[req_idx] <= 1'b1;
        dirty_bits[req_idx] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: CacheWay and memory models, a response scoreboard,
// and a memory request log checked step by step.
module tb_cache_ctrl;
  localparam logic [127:0] LINE0 = {32'h0000_DDDD, 32'h0000_CCCC, 32'h0000_BBBB, 32'h0000_AAAA};

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req_valid, cpu_req_we;
  logic [31:0]  cpu_req_addr, cpu_req_wdata;
  logic [3:0]   cpu_req_byte_en;
  logic         cpu_req_ready, cpu_resp_valid;
  logic [31:0]  cpu_resp_rdata;
  logic [4:0]   way_addr;
  logic         way_wr_en;
  logic [127:0] way_wr_data;
  logic [22:0]  way_wr_tag;
  logic [3:0]   way_wr_word_en, way_wr_byte_en;
  logic [22:0]  way_tag_data;
  logic [127:0] way_rd_data;
  logic         mem_req_valid, mem_req_we, mem_req_ready, mem_resp_valid;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata, mem_resp_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_byte_en(cpu_req_byte_en),
    .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .way_addr(way_addr), .way_wr_en(way_wr_en), .way_wr_data(way_wr_data), .way_wr_tag(way_wr_tag),
    .way_wr_word_en(way_wr_word_en), .way_wr_byte_en(way_wr_byte_en),
    .way_tag_data(way_tag_data), .way_rd_data(way_rd_data),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // CacheWay model: combinational read, byte/word-masked write on posedge
  logic [22:0]  cw_tag [32];
  logic [127:0] cw_data[32];
  logic [127:0] cw_merge;
  int           wr_cnt = 0;
  logic [3:0]   last_word_en = '0, last_byte_en = '0;

  assign way_tag_data = cw_tag[way_addr];
  assign way_rd_data  = cw_data[way_addr];

  always_comb begin
    cw_merge = cw_data[way_addr];
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++)
        if (way_wr_word_en[w] && way_wr_byte_en[b])
          cw_merge[w*32 + b*8 +: 8] = way_wr_data[w*32 + b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (way_wr_en) begin
      cw_tag[way_addr]  <= way_wr_tag;
      cw_data[way_addr] <= cw_merge;
      wr_cnt            <= wr_cnt + 1;
      last_word_en      <= way_wr_word_en;
      last_byte_en      <= way_wr_byte_en;
    end
  end

  // Memory model: backing store, configurable stall, request log
  logic [127:0] mem [logic [31:0]];
  logic         log_we[$];
  logic [31:0]  log_addr[$];
  logic [127:0] log_wdata[$];
  int           log_rd = 0;
  int           mem_stall = 0, stall_cnt = 0, stall_cycles = 0, stable_err = 0;
  int           kick_req = 0, kick_done = 0;
  logic         hold_resp = 1'b0, resp_pending = 1'b0, snap_we = 1'b0;
  logic [31:0]  snap_addr = '0;
  logic [127:0] resp_line = '0;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a ^ 32'hC3C3_0003, a ^ 32'hC3C3_0002, a ^ 32'hC3C3_0001, a ^ 32'hC3C3_0000};
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [127:0] l;
    l = line_of({a[31:4], 4'b0});
    return l[a[3:2]*32 +: 32];
  endfunction

  initial begin : mem_model
    mem[32'h10]    = LINE0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (rst) begin
        stall_cnt    = 0;
        resp_pending = 1'b0;
      end else if (resp_pending) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = resp_line;
        resp_pending   = 1'b0;
      end else if (kick_done != kick_req) begin
        kick_done      = kick_req;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = {4{32'hBAD0_F00D}};
      end else if (mem_req_valid || stall_cnt != 0) begin
        if (stall_cnt == 0) begin
          snap_we   = mem_req_we;
          snap_addr = mem_req_addr;
        end else if (!mem_req_valid || mem_req_we !== snap_we || mem_req_addr !== snap_addr || cpu_req_ready) begin
          stable_err++;
        end
        if (stall_cnt < mem_stall) begin
          stall_cnt++;
          stall_cycles++;
        end else begin
          stall_cnt     = 0;
          mem_req_ready = 1'b1;
          log_we.push_back(mem_req_we);
          log_addr.push_back(mem_req_addr);
          log_wdata.push_back(mem_req_wdata);
          if (mem_req_we) mem[mem_req_addr] = mem_req_wdata;
          else if (!hold_resp) begin
            resp_pending = 1'b1;
            resp_line    = line_of(mem_req_addr);
          end
        end
      end
    end
  end

  // Checking and driver tasks
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_mem(input string tag, input logic we, input logic [31:0] addr,
                            input logic [127:0] wdata);
    check({tag, "_issued"}, log_addr.size() > log_rd, 1'b1);
    if (log_addr.size() > log_rd) begin
      check({tag, "_we"}, log_we[log_rd], we);
      check({tag, "_addr"}, log_addr[log_rd], addr);
      if (we) check({tag, "_wdata"}, log_wdata[log_rd], wdata);
      log_rd++;
    end
  endtask

  task automatic cpu_op(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, output int lat);
    int n;
    logic [31:0] exp_v;
    exp_q.push_back(exp_rdata);
    lat = -1;
    @(negedge clk);
    cpu_req_valid   = 1'b1;
    cpu_req_we      = we;
    cpu_req_addr    = addr;
    cpu_req_wdata   = wdata;
    cpu_req_byte_en = be;
    n = 0;
    while (!cpu_req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    cpu_req_valid   = 1'b0;
    cpu_req_we      = 1'b0;
    cpu_req_wdata   = '0;
    cpu_req_byte_en = '0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (cpu_resp_valid) begin
        lat = c;
        break;
      end
    end
    exp_v = exp_q.pop_front();
    if (lat < 0) check({tag, "_resp_timeout"}, 1'b0, 1'b1);
    else         check({tag, "_rdata"}, cpu_resp_rdata, exp_v);
  endtask

  // Directed sequence
  initial begin : main_seq
    logic [127:0] line0_v, merged;
    int lat, n, wr_before, stall_before, err_before;
    line0_v         = LINE0;
    rst             = 1'b1;
    cpu_req_valid   = 1'b0;
    cpu_req_we      = 1'b0;
    cpu_req_addr    = '0;
    cpu_req_wdata   = '0;
    cpu_req_byte_en = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", cpu_req_ready, 1'b1);
    check("rst_resp_valid", cpu_resp_valid, 1'b0);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_way_wr", way_wr_en, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Cold miss with line fill
    wr_before = wr_cnt;
    cpu_op("t1_load", 1'b0, 32'h0000_0010, '0, '0, 32'h0000_AAAA, lat);
    expect_mem("t1_fill", 1'b0, 32'h0000_0010, '0);
    check("t1_fill_writes", wr_cnt - wr_before, 1);

    // Read hit: response in the cycle after the accept cycle, no memory traffic
    cpu_op("t2_load", 1'b0, 32'h0000_0014, '0, '0, 32'h0000_BBBB, lat);
    check("t2_latency", lat, 1);
    check("t2_no_mem", log_addr.size() - log_rd, 0);

    // Store hit with partial byte enables
    wr_before = wr_cnt;
    cpu_op("t3_store", 1'b1, 32'h0000_0018, 32'h1122_3344, 4'b0011, 32'h0, lat);
    check("t3_latency", lat, 1);
    @(posedge clk);
    #1;
    check("t3_word_en", last_word_en, 4'b0100);
    check("t3_byte_en", last_byte_en, 4'b0011);
    check("t3_writes", wr_cnt - wr_before, 1);
    cpu_op("t3_readback", 1'b0, 32'h0000_0018, '0, '0, {line0_v[95:80], 16'h3344}, lat);

    // Conflict miss on a dirty set: writeback of the merged line, then fill
    merged = line0_v;
    merged[79:64] = 16'h3344;
    cpu_op("t4_load", 1'b0, 32'h0000_0210, '0, '0, word_of(32'h0000_0210), lat);
    expect_mem("t4_wb", 1'b1, 32'h0000_0010, merged);
    expect_mem("t4_fill", 1'b0, 32'h0000_0210, '0);
    // Set is now clean: evicting it again must go straight to a read
    cpu_op("t4_back", 1'b0, 32'h0000_0010, '0, '0, 32'h0000_AAAA, lat);
    expect_mem("t4_clean", 1'b0, 32'h0000_0010, '0);
    cpu_op("t4_merged", 1'b0, 32'h0000_0018, '0, '0, 32'h0000_3344, lat);
    check("t4_merged_latency", lat, 1);

    // Refill request held off for 5 cycles
    stall_before = stall_cycles;
    err_before   = stable_err;
    mem_stall    = 5;
    cpu_op("t5_load", 1'b0, 32'h0000_0420, '0, '0, word_of(32'h0000_0420), lat);
    mem_stall    = 0;
    check("t5_stall_cycles", stall_cycles - stall_before, 5);
    check("t5_stable", stable_err - err_before, 0);
    expect_mem("t5_fill", 1'b0, 32'h0000_0420, '0);

    // Reset while waiting for the fill; the late response must be ignored
    hold_resp = 1'b1;
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = 32'h0000_0830;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    n = 0;
    while (log_addr.size() == log_rd && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("t6_grant", log_addr.size() > log_rd, 1'b1);
    #1 rst = 1'b1;
    wr_before = wr_cnt;
    @(posedge clk);
    #1 rst = 1'b0;
    hold_resp = 1'b0;
    kick_req++;
    repeat (3) @(negedge clk);
    check("t6_no_fill", wr_cnt - wr_before, 0);
    check("t6_mem_idle", mem_req_valid, 1'b0);
    check("t6_ready", cpu_req_ready, 1'b1);
    check("t6_no_resp", cpu_resp_valid, 1'b0);
    expect_mem("t6_pre", 1'b0, 32'h0000_0830, '0);
    cpu_op("t6_reload", 1'b0, 32'h0000_0830, '0, '0, word_of(32'h0000_0830), lat);
    expect_mem("t6_refetch", 1'b0, 32'h0000_0830, '0);
    cpu_op("t6_set1", 1'b0, 32'h0000_0010, '0, '0, 32'h0000_AAAA, lat);
    expect_mem("t6_set1_miss", 1'b0, 32'h0000_0010, '0);

    check("sb_empty", exp_q.size(), 0);
    check("log_drained", log_addr.size() - log_rd, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
